// File: rtl/os_readout_fifo.sv
// Readout buffer between the trigger/readout pipeline and the JTAG OSread register.
// Presents {not_empty, head_word} on OS; pops once per synchronised OSre rising edge.
module os_readout_fifo #(
  parameter int DW = 48,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          hard_rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          fifo_clr,
  input  logic          OSre,
  output logic [DW:0]   OS,
  output logic [AW:0]   fifo_cnt,
  output logic          ovf
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [DW:0]   os_q, os_d;
  logic          re_s1_q, re_s2_q, re_s3_q;

  logic          empty, full, pop_req, pop_acc, wr_acc;
  logic [DW-1:0] head;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign pop_req = re_s2_q & ~re_s3_q;
  assign pop_acc = ~fifo_clr & pop_req & ~empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts the write.
  assign wr_acc  = ~fifo_clr & wr_en & (~full | pop_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (fifo_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (pop_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_acc)  wr_ptr_d = wr_ptr_q + AW'(1);
      if (wr_en && !wr_acc) ovf_d = 1'b1;
      count_d = count_q + (AW+1)'(wr_acc) - (AW+1)'(pop_acc);
    end
  end

  // The slot being written this cycle is not in mem yet; forward wr_data when it becomes head.
  always_comb begin
    if (wr_acc && (rd_ptr_d == wr_ptr_q)) head = wr_data;
    else                                 head = mem[rd_ptr_d];
    os_d = (count_d != '0) ? {1'b1, head} : '0;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge hard_rst) begin
    if (!hard_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      os_q     <= '0;
      re_s1_q  <= 1'b0;
      re_s2_q  <= 1'b0;
      re_s3_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      os_q     <= os_d;
      re_s1_q  <= OSre;
      re_s2_q  <= re_s1_q;
      re_s3_q  <= re_s2_q;
    end
  end

  assign OS       = os_q;
  assign fifo_cnt = count_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_os_readout_fifo.sv
// Directed bench for os_readout_fifo: fill, OSre pops, overflow, full write+pop, clear, wrap, async reset.
module tb_os_readout_fifo;

  logic        clk = 1'b0;
  logic        hard_rst;
  logic        wr_en;
  logic [47:0] wr_data;
  logic        fifo_clr;
  logic        OSre;
  logic [48:0] OS;
  logic [4:0]  fifo_cnt;
  logic        ovf;

  int n_vec = 0;
  int n_err = 0;
  logic [47:0] ref_q [$];

  always #5 clk = ~clk;

  os_readout_fifo #(.DW(48), .AW(4)) dut (
    .clk      (clk),
    .hard_rst (hard_rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .fifo_clr (fifo_clr),
    .OSre     (OSre),
    .OS       (OS),
    .fifo_cnt (fifo_cnt),
    .ovf      (ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("vec %0d %s ok (%h)", n_vec, tag, obs);
    end
  endtask

  function automatic logic [63:0] osw(input logic [47:0] d);
    return {15'd0, 1'b1, d};
  endfunction

  // Called at a negedge; returns at a negedge.
  task automatic wr_word(input logic [47:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic pulse_os();
    OSre = 1'b1;
    repeat (4) @(negedge clk);
    OSre = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    hard_rst = 1'b0; wr_en = 1'b0; wr_data = '0; fifo_clr = 1'b0; OSre = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_os", 64'(OS), 64'd0);
    chk("rst_cnt", 64'(fifo_cnt), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    hard_rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_os", 64'(OS), 64'd0);
    chk("idle_cnt", 64'(fifo_cnt), 64'd0);

    // Fill three words
    wr_word(48'h1);
    chk("fill_os1", 64'(OS), osw(48'h1));
    chk("fill_cnt1", 64'(fifo_cnt), 64'd1);
    wr_word(48'h2);
    wr_word(48'h3);
    chk("fill_cnt3", 64'(fifo_cnt), 64'd3);
    chk("fill_head", 64'(OS), osw(48'h1));

    // First pop with latency checks
    OSre = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pop_lat_e1", 64'(fifo_cnt), 64'd3);
    @(negedge clk);
    chk("pop_lat_e2", 64'(fifo_cnt), 64'd2);
    chk("pop_os2", 64'(OS), osw(48'h2));
    @(negedge clk);
    OSre = 1'b0;
    repeat (4) @(negedge clk);
    chk("pop_once", 64'(fifo_cnt), 64'd2);

    pulse_os();
    chk("pop_os3", 64'(OS), osw(48'h3));
    chk("pop_cnt1", 64'(fifo_cnt), 64'd1);
    pulse_os();
    chk("pop_empty_os", 64'(OS), 64'd0);
    chk("pop_empty_cnt", 64'(fifo_cnt), 64'd0);
    pulse_os();
    chk("pop_extra_os", 64'(OS), 64'd0);
    chk("pop_extra_cnt", 64'(fifo_cnt), 64'd0);
    chk("pop_extra_ovf", 64'(ovf), 64'd0);

    // Overflow: 17 writes, word 16 lost
    for (int i = 0; i <= 16; i++) begin
      wr_word(48'(i));
      if (i == 15) begin
        chk("ovf_cnt_full", 64'(fifo_cnt), 64'd16);
        chk("ovf_not_yet", 64'(ovf), 64'd0);
      end
    end
    chk("ovf_cnt", 64'(fifo_cnt), 64'd16);
    chk("ovf_set", 64'(ovf), 64'd1);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_order", 64'(OS), osw(48'(i)));
      pulse_os();
    end
    chk("ovf_drain_cnt", 64'(fifo_cnt), 64'd0);
    chk("ovf_drain_os", 64'(OS), 64'd0);
    chk("ovf_sticky", 64'(ovf), 64'd1);

    fifo_clr = 1'b1;
    @(negedge clk);
    fifo_clr = 1'b0;
    chk("clr_ovf", 64'(ovf), 64'd0);

    // Full FIFO: write coincident with pop_req
    for (int i = 0; i < 16; i++) wr_word(48'(100 + i));
    chk("full_cnt", 64'(fifo_cnt), 64'd16);
    OSre = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr_en = 1'b1; wr_data = 48'd116;
    @(negedge clk);
    wr_en = 1'b0;
    chk("fullwp_cnt", 64'(fifo_cnt), 64'd16);
    chk("fullwp_ovf", 64'(ovf), 64'd0);
    chk("fullwp_os", 64'(OS), osw(48'd101));
    @(negedge clk);
    OSre = 1'b0;
    repeat (4) @(negedge clk);

    wr_word(48'd117);
    chk("full_drop_ovf", 64'(ovf), 64'd1);
    chk("full_drop_cnt", 64'(fifo_cnt), 64'd16);
    for (int i = 0; i < 11; i++) begin
      chk("pre_clr_order", 64'(OS), osw(48'(101 + i)));
      pulse_os();
    end
    chk("pre_clr_cnt", 64'(fifo_cnt), 64'd5);

    // Clear with concurrent write
    fifo_clr = 1'b1; wr_en = 1'b1; wr_data = 48'd999;
    @(negedge clk);
    fifo_clr = 1'b0; wr_en = 1'b0;
    chk("clr_cnt", 64'(fifo_cnt), 64'd0);
    chk("clr_ovf2", 64'(ovf), 64'd0);
    chk("clr_os", 64'(OS), 64'd0);

    // Interleaved traffic across the pointer wrap
    ref_q.delete();
    for (int i = 0; i < 40; i++) begin
      if ((i % 3 == 2) && (ref_q.size() > 0)) begin
        chk("wrap_head", 64'(OS), osw(ref_q[0]));
        pulse_os();
        void'(ref_q.pop_front());
      end else if (ref_q.size() < 16) begin
        wr_word(48'h1000 + 48'(i));
        ref_q.push_back(48'h1000 + 48'(i));
      end
      chk("wrap_cnt", 64'(fifo_cnt), 64'(ref_q.size()));
    end
    while (ref_q.size() > 0) begin
      chk("wrap_drain", 64'(OS), osw(ref_q[0]));
      pulse_os();
      void'(ref_q.pop_front());
    end
    chk("wrap_end_cnt", 64'(fifo_cnt), 64'd0);
    chk("wrap_end_os", 64'(OS), 64'd0);

    // Asynchronous reset while OSre is high and 7 words are stored
    for (int i = 0; i < 7; i++) wr_word(48'(200 + i));
    chk("ar_pre_cnt", 64'(fifo_cnt), 64'd7);
    OSre = 1'b1;
    @(negedge clk);
    #2;
    hard_rst = 1'b0;
    #1;
    chk("ar_os", 64'(OS), 64'd0);
    chk("ar_cnt", 64'(fifo_cnt), 64'd0);
    chk("ar_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    hard_rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("ar_rel_cnt", 64'(fifo_cnt), 64'd0);
    chk("ar_rel_os", 64'(OS), 64'd0);
    wr_word(48'd42);
    repeat (2) @(negedge clk);
    chk("ar_wr_cnt", 64'(fifo_cnt), 64'd1);
    chk("ar_wr_os", 64'(OS), osw(48'd42));
    OSre = 1'b0;
    repeat (3) @(negedge clk);
    chk("ar_hold_cnt", 64'(fifo_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
